// File: rtl/result_writer_pkg.sv
// Shared types and constants for the result memory write sequencer.
package result_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int ADDR_STEP = 4;

endpackage

// File: rtl/result_writer_word_counter.sv
// Loadable down-counter tracking words left in a transfer; last flags value==1.
module word_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld,
    input  logic                 dec,
    input  logic [CNT_WIDTH-1:0] ld_val,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (ld) begin
            count_d = ld_val;
        end else if (dec) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/result_writer.sv
// Writer-side address sequencer: one RAM write per accepted result word,
// byte addresses stepping by 4 from a word-aligned base.
module result_writer
    import result_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  done_q, done_d;
    logic                  cnt_ld, cnt_dec, cnt_last;
    logic                  accept;

    word_counter #(.CNT_WIDTH(CNT_WIDTH)) u_word_counter (
        .clk    (clk),
        .rst    (rst),
        .ld     (cnt_ld),
        .dec    (cnt_dec),
        .ld_val (num_words),
        .last   (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mem_wr_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_ld      = 1'b0;
        cnt_dec     = 1'b0;
        // Ready depends on state alone so the producer sees no in_valid loop.
        in_ready    = (state_q == WRITE);
        busy        = (state_q != IDLE);
        accept      = in_valid & in_ready;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr & ~ADDR_WIDTH'(3);
                    cnt_ld  = 1'b1;
                    state_d = (num_words == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + ADDR_WIDTH'(ADDR_STEP);
                    cnt_dec     = 1'b1;
                    if (cnt_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
        end
    end

    assign mem_wr_en = mem_wr_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: expected writes are queued as words are offered.
module tb_result_writer;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int CW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_words;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;

    wr_t  exp_q[$];
    logic exp_wr_next;
    int   vectors = 0;
    int   miscompares = 0;

    result_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance one clock, sample 1ns later, and check write strobe/data and done.
    task automatic clk_step(input logic exp_done);
        wr_t w;
        @(posedge clk);
        #1;
        chk("mem_wr_en", {31'b0, mem_wr_en}, {31'b0, exp_wr_next});
        if (exp_wr_next && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("mem_addr", {16'b0, mem_addr}, {16'b0, w.addr});
            chk("mem_wdata", mem_wdata, w.data);
        end
        exp_wr_next = 1'b0;
        chk("done", {31'b0, done}, {31'b0, exp_done});
    endtask

    task automatic chk_state(input string tag, input logic exp_busy, input logic exp_ready);
        chk({tag, "_busy"}, {31'b0, busy}, {31'b0, exp_busy});
        chk({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, exp_ready});
    endtask

    task automatic begin_xfer(input logic [AW-1:0] base, input logic [CW-1:0] n);
        start = 1'b1; base_addr = base; num_words = n; in_valid = 1'b0;
        clk_step(n == 0);
        start = 1'b0;
    endtask

    task automatic word(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic last);
        in_valid = 1'b1; in_data = d;
        exp_q.push_back('{addr: a, data: d});
        exp_wr_next = 1'b1;
        clk_step(last);
        in_valid = 1'b0;
    endtask

    task automatic stall();
        in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
        clk_step(1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        in_valid = 1'b0; in_data = '0; exp_wr_next = 1'b0;
        clk_step(1'b0);
        clk_step(1'b0);
        chk_state("reset", 1'b0, 1'b0);
        chk("reset_addr", {16'b0, mem_addr}, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        clk_step(1'b0);

        // Basic back-to-back transfer
        begin_xfer(16'h0100, 8'd3);
        chk_state("basic_start", 1'b1, 1'b1);
        word(32'hA, 16'h0100, 1'b0);
        word(32'hB, 16'h0104, 1'b0);
        word(32'hC, 16'h0108, 1'b1);
        chk_state("basic_done", 1'b1, 1'b0);
        clk_step(1'b0);
        chk_state("basic_idle", 1'b0, 1'b0);

        // Stalls between words
        begin_xfer(16'h0100, 8'd3);
        word(32'h11, 16'h0100, 1'b0);
        stall();
        stall();
        chk_state("stall_hold", 1'b1, 1'b1);
        word(32'h22, 16'h0104, 1'b0);
        stall();
        stall();
        word(32'h33, 16'h0108, 1'b1);
        clk_step(1'b0);
        chk_state("stall_idle", 1'b0, 1'b0);

        // Zero count; start held in DONE cycle is ignored, honoured in IDLE
        begin_xfer(16'h0040, 8'd0);
        chk_state("zero_done", 1'b1, 1'b0);
        start = 1'b1; base_addr = 16'h0500; num_words = 8'd1;
        clk_step(1'b0);
        chk_state("zero_idle", 1'b0, 1'b0);
        clk_step(1'b0);
        start = 1'b0;
        chk_state("restart", 1'b1, 1'b1);
        word(32'h55, 16'h0500, 1'b1);
        clk_step(1'b0);

        // Wrap and alignment
        begin_xfer(16'hFFFB, 8'd3);
        word(32'h1, 16'hFFF8, 1'b0);
        word(32'h2, 16'hFFFC, 1'b0);
        word(32'h3, 16'h0000, 1'b1);
        clk_step(1'b0);

        // Reset mid-transfer
        begin_xfer(16'h0200, 8'd5);
        word(32'h71, 16'h0200, 1'b0);
        word(32'h72, 16'h0204, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h73;
        clk_step(1'b0);
        rst = 1'b0; in_valid = 1'b0;
        chk_state("rst_mid", 1'b0, 1'b0);
        chk("rst_mid_addr", {16'b0, mem_addr}, 32'h0);
        chk("rst_mid_wdata", mem_wdata, 32'h0);
        clk_step(1'b0);
        chk_state("rst_mid_idle", 1'b0, 1'b0);
        begin_xfer(16'h0300, 8'd2);
        word(32'h81, 16'h0300, 1'b0);
        word(32'h82, 16'h0304, 1'b1);
        clk_step(1'b0);

        // start while busy is ignored
        begin_xfer(16'h0400, 8'd3);
        start = 1'b1; base_addr = 16'h0800; num_words = 8'd7;
        word(32'h91, 16'h0400, 1'b0);
        word(32'h92, 16'h0404, 1'b0);
        start = 1'b0;
        word(32'h93, 16'h0408, 1'b1);
        clk_step(1'b0);
        chk_state("busy_start_idle", 1'b0, 1'b0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_writer.md
# result_writer

Writer-side address sequencer for the CNN result memory: accepts a stream of result words over a valid/ready handshake and issues one memory write per word. Write addresses start at a programmed byte base and step by 4 per word. It is the write-direction counterpart of the instruction/data address counter that walks memory for reads. It sits between the compute datapath (producer) and the result RAM write port, and reports completion to the top-level controller.

## Interface
- ADDR_WIDTH, 16, byte-address width of the memory port
- DATA_WIDTH, 32, word width
- CNT_WIDTH, 8, width of the word-count field
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a transfer; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first byte address; bits [1:0] ignored (treated as 0)
- num_words  in  CNT_WIDTH  number of words to write; 0 allowed
- in_valid  in  1  producer has a word on in_data
- in_data  in  DATA_WIDTH  result word
- in_ready  out  1  block accepts a word this cycle
- mem_wr_en  out  1  write strobe to result RAM
- mem_addr  out  ADDR_WIDTH  write byte address
- mem_wdata  out  DATA_WIDTH  write data
- busy  out  1  transfer in progress (state != IDLE)
- done  out  1  one-cycle pulse at end of transfer

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: in_ready=0. On start=1, latch {base_addr[ADDR_WIDTH-1:2],2'b00} into addr register and num_words into remaining counter.
  - num_words != 0 -> WRITE.
  - num_words == 0 -> DONE (no writes issued).
- WRITE: in_ready=1 (decoded from state only, no combinational path from in_valid). Accept = in_valid & in_ready.
  - On accept: next cycle mem_wr_en=1, mem_addr=current addr, mem_wdata=in_data. Then addr += 4, remaining -= 1.
  - The accept that consumes the last word (remaining==1) -> DONE.
  - No accept: mem_wr_en=0 next cycle; addr and remaining hold.
- DONE: done=1 for exactly this cycle, then IDLE unconditionally.
- start is ignored outside IDLE. start asserted in the done cycle is ignored; it is honoured one cycle later in IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Incrementing past the top wraps to 0 with no error flag.
- in_data is sampled only on accept. in_valid while not ready is left pending; the producer must hold it.

## Timing
- Reset: state=IDLE. in_ready, mem_wr_en, busy, done = 0. mem_addr, mem_wdata, addr, remaining = 0.
- Reset mid-transfer aborts: no done pulse, and any pending write strobe is cleared in the reset cycle.
- Registered outputs: mem_wr_en, mem_addr, mem_wdata, done. Combinational from state: in_ready, busy.
- Accept-to-write latency: 1 cycle.
- Throughput: 1 word/cycle with in_valid held high.
- N-word transfer with no stalls: start in cycle 0, WRITE in cycles 1..N, DONE in cycle N+1.
  - Writes appear in cycles 2..N+1; the last write coincides with the done pulse.
  - in_ready falls in cycle N+1.
- num_words=0: start in cycle 0, done in cycle 1, no mem_wr_en.

## Structure
- Shared package result_writer_pkg:
  - state enum {IDLE, WRITE, DONE}
  - localparam ADDR_STEP = 4
- Address register and +4 increment reuse the team's existing register and adder primitives.
- One natural sub-module: word_counter, a loadable down-counter of width CNT_WIDTH with ld, dec, and a last flag (value==1).
- FSM and output registers live in result_writer.

## Test plan
- Basic: base=0x0100, num_words=3, in_valid held high, data 0xA,0xB,0xC -> writes (0x0100,0xA),(0x0104,0xB),(0x0108,0xC) in consecutive cycles; done in the same cycle as the last write; busy drops the next cycle.
- Stalls: same transfer with in_valid low for 2 cycles between words -> no mem_wr_en in stall cycles; addresses still contiguous.
- Zero count: num_words=0 -> done one cycle after start; mem_wr_en never asserted; in_ready never asserted.
- Wrap and alignment, ADDR_WIDTH=16: base=0xFFFB, num_words=3 -> addresses 0xFFF8, 0xFFFC, 0x0000.
- Reset mid-transfer: rst after 2 of 5 words -> all outputs 0 next cycle; no done; a fresh start then writes from the new base correctly.
- start while busy: pulse start during WRITE with a different base -> ignored; the original transfer completes unchanged.
